// File: rtl/event_counter_sync.sv
// event_counter_sync: synchronised edge counter with a programmable trigger pulse.
// The event line is brought into the clk_i domain. Selected edges are counted
// while ARMED. When the count reaches the threshold latched at arm time, a
// registered trigger pulse of the latched length is produced. After the pulse
// the block either re-arms automatically or parks in DONE.
module event_counter_sync #(
  parameter int WIDTH       = 32,
  parameter int PULSE_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   event_i,
  input  logic                   arm_i,
  input  logic                   disarm_i,
  input  logic [1:0]             edge_sel_i,
  input  logic                   rearm_i,
  input  logic [WIDTH-1:0]       threshold_i,
  input  logic [PULSE_WIDTH-1:0] pulse_len_i,
  output logic [WIDTH-1:0]       count_o,
  output logic                   trigger_o,
  output logic                   armed_o,
  output logic                   fired_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]       ONE_W = WIDTH'(1);
  localparam logic [PULSE_WIDTH-1:0] ONE_P = PULSE_WIDTH'(1);

  state_t                   state;
  state_t                   state_next;
  logic [SYNC_STAGES-1:0]   sync_p0;
  logic                     hist_p1;
  logic                     ev_now;
  logic                     rise;
  logic                     fall;
  logic                     edge_hit;
  logic [WIDTH-1:0]         count;
  logic [WIDTH-1:0]         count_inc;
  logic [WIDTH-1:0]         thr_lat;
  logic [PULSE_WIDTH-1:0]   plen_lat;
  logic [PULSE_WIDTH-1:0]   pcnt;
  logic                     fired;
  logic                     do_arm;
  logic                     fire_hit;
  logic                     enter_fire;
  logic                     pulse_end;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == {WIDTH{1'b1}}) begin
      return v;
    end
    return v + ONE_W;
  endfunction

  // A zero length or threshold would never complete, so zero is promoted to one.
  function automatic logic [WIDTH-1:0] min_one_w(input logic [WIDTH-1:0] v);
    return (v == '0) ? ONE_W : v;
  endfunction

  function automatic logic [PULSE_WIDTH-1:0] min_one_p(input logic [PULSE_WIDTH-1:0] v);
    return (v == '0) ? ONE_P : v;
  endfunction

  // Synchroniser chain followed by one history flop for edge comparison.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], event_i};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // --- stage boundary: synchronised level vs. history -> qualifying edge ---
  assign ev_now = sync_p0[SYNC_STAGES-1];
  assign rise   = ev_now & ~hist_p1;
  assign fall   = ~ev_now & hist_p1;

  // Edge selection is live: 00/11 rising, 01 falling, 10 both.
  always_comb begin
    edge_hit = rise;
    case (edge_sel_i)
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise | fall;
      default: edge_hit = rise;
    endcase
  end

  // disarm beats arm, arm beats a coincident edge.
  assign do_arm     = arm_i & ~disarm_i;
  assign count_inc  = sat_inc(count);
  assign fire_hit   = (state == ARMED) & edge_hit & (count_inc == thr_lat);
  assign enter_fire = fire_hit & ~arm_i & ~disarm_i;
  assign pulse_end  = (state == FIRE) & (pcnt == plen_lat);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (disarm_i) begin
      state_next = IDLE;
    end else if (arm_i) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED: if (fire_hit) state_next = FIRE;
        FIRE:  if (pulse_end) state_next = rearm_i ? ARMED : DONE;
        default: state_next = state;
      endcase
    end
  end

  // Output decode straight from registered state and counters.
  always_comb begin
    count_o   = count;
    trigger_o = (state == FIRE);
    armed_o   = (state == ARMED);
    fired_o   = fired;
  end

  // Configuration is captured only on an effective arm; auto-rearm reuses it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thr_lat  <= '0;
      plen_lat <= '0;
    end else if (do_arm) begin
      thr_lat  <= min_one_w(threshold_i);
      plen_lat <= min_one_p(pulse_len_i);
    end
  end

  // Edge counter: cleared by arm or by auto-rearm, held by disarm.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (!disarm_i) begin
      if (arm_i) begin
        count <= '0;
      end else if ((state == ARMED) && edge_hit) begin
        count <= count_inc;
      end else if (pulse_end && rearm_i) begin
        count <= '0;
      end
    end
  end

  // Pulse length counter: 1 on the first FIRE cycle, expiry when it equals the length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt <= '0;
    end else if (enter_fire) begin
      pcnt <= ONE_P;
    end else if (state == FIRE) begin
      pcnt <= pcnt + ONE_P;
    end
  end

  // Sticky fired flag, set with the trigger and cleared only by arm.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fired <= 1'b0;
    end else if (do_arm) begin
      fired <= 1'b0;
    end else if (enter_fire) begin
      fired <= 1'b1;
    end
  end

endmodule

// File: tb/tb_event_counter_sync.sv
// Bench for event_counter_sync (WIDTH=4). Stimulus pushes the expected sequence
// of output changes, {count, trigger, armed, fired}, each with the expected number
// of clock cycles since the previous change (0 = any). A monitor pops one entry
// whenever the observed output tuple changes.
module tb_event_counter_sync;

  localparam int W  = 4;
  localparam int PW = 16;

  logic          clk;
  logic          rst_i;
  logic          event_i;
  logic          arm_i;
  logic          disarm_i;
  logic [1:0]    edge_sel_i;
  logic          rearm_i;
  logic [W-1:0]  threshold_i;
  logic [PW-1:0] pulse_len_i;
  logic [W-1:0]  count_o;
  logic          trigger_o;
  logic          armed_o;
  logic          fired_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [6:0] exp_val_q[$];
  int         exp_dly_q[$];
  string      exp_tag_q[$];

  logic [6:0] prev = 7'h7F;
  logic [6:0] cur;
  logic [6:0] ev_val;
  int         ev_dly;
  string      ev_tag;
  int         dl;

  event_counter_sync #(.WIDTH(W), .PULSE_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .event_i     (event_i),
    .arm_i       (arm_i),
    .disarm_i    (disarm_i),
    .edge_sel_i  (edge_sel_i),
    .rearm_i     (rearm_i),
    .threshold_i (threshold_i),
    .pulse_len_i (pulse_len_i),
    .count_o     (count_o),
    .trigger_o   (trigger_o),
    .armed_o     (armed_o),
    .fired_o     (fired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output tuple consumes one expected entry.
  always @(negedge clk) begin
    cur = {count_o, trigger_o, armed_o, fired_o};
    if (cur !== prev) begin
      checks++;
      dl = cyc - last_cyc;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got cnt=%0d trig=%0b armed=%0b fired=%0b, no change expected",
                 cur[6:3], cur[2], cur[1], cur[0]);
      end else begin
        ev_val = exp_val_q.pop_front();
        ev_dly = exp_dly_q.pop_front();
        ev_tag = exp_tag_q.pop_front();
        if (cur !== ev_val || (ev_dly != 0 && dl != ev_dly)) begin
          errors++;
          $display("FAIL %s: got cnt=%0d trig=%0b armed=%0b fired=%0b after %0d cyc, want cnt=%0d trig=%0b armed=%0b fired=%0b after %0d cyc",
                   ev_tag, cur[6:3], cur[2], cur[1], cur[0], dl,
                   ev_val[6:3], ev_val[2], ev_val[1], ev_val[0], ev_dly);
        end
      end
      prev = cur;
      last_cyc = cyc;
    end
  end

  task automatic ex(input logic [3:0] c, input logic t, input logic a, input logic f,
                    input int d, input string tag);
    exp_val_q.push_back({c, t, a, f});
    exp_dly_q.push_back(d);
    exp_tag_q.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic v, input int n);
    event_i = v;
    step(n);
  endtask

  task automatic arm(input logic [W-1:0] thr, input logic [PW-1:0] plen,
                     input logic [1:0] sel, input logic rr);
    threshold_i = thr;
    pulse_len_i = plen;
    edge_sel_i  = sel;
    rearm_i     = rr;
    arm_i       = 1'b1;
    step(1);
    arm_i       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; event_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0;
    edge_sel_i = 2'b00; rearm_i = 1'b0; threshold_i = '0; pulse_len_i = '0;
    ex(0, 0, 0, 0, 0, "reset");
    #2 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    step(2);

    // Test 1: rising, threshold 3, 4-cycle pulse, one-shot; 4th edge ignored.
    ex(0, 0, 1, 0, 0, "t1_arm");
    ex(1, 0, 1, 0, 3, "t1_cnt1");
    ex(2, 0, 1, 0, 8, "t1_cnt2");
    ex(3, 1, 0, 1, 8, "t1_fire");
    ex(3, 0, 0, 1, 4, "t1_done");
    arm(4'd3, 16'd4, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin ev(1'b1, 4); ev(1'b0, 4); end

    // Test 2: both edges, threshold 4; first count 3 cycles after the transition.
    ex(0, 0, 1, 0, 0, "t2_arm");
    ex(1, 0, 1, 0, 3, "t2_latency");
    ex(2, 0, 1, 0, 4, "t2_cnt2");
    ex(3, 0, 1, 0, 4, "t2_cnt3");
    ex(4, 1, 0, 1, 4, "t2_fire");
    ex(4, 0, 0, 1, 2, "t2_done");
    arm(4'd4, 16'd2, 2'b10, 1'b0);
    for (int i = 0; i < 2; i++) begin ev(1'b1, 4); ev(1'b0, 4); end
    step(4);

    // Test 3: auto-rearm, threshold 2, 1-cycle pulse; then an edge during FIRE.
    ex(0, 0, 1, 0, 0, "t3_arm");
    ex(1, 0, 1, 0, 3, "t3_a_cnt1");
    ex(2, 1, 0, 1, 8, "t3_a_fire");
    ex(0, 0, 1, 1, 1, "t3_a_rearm");
    for (int k = 0; k < 2; k++) begin
      ex(1, 0, 1, 1, 7, "t3_b_cnt1");
      ex(2, 1, 0, 1, 8, "t3_b_fire");
      ex(0, 0, 1, 1, 1, "t3_b_rearm");
    end
    arm(4'd2, 16'd1, 2'b00, 1'b1);
    for (int i = 0; i < 6; i++) begin ev(1'b1, 4); ev(1'b0, 4); end
    ex(1, 0, 1, 1, 7, "t3_c_cnt1");
    ex(2, 1, 0, 1, 1, "t3_c_fire");
    ex(0, 0, 1, 1, 1, "t3_c_fire_edge_dropped");
    edge_sel_i = 2'b10;
    ev(1'b1, 1); ev(1'b0, 1); ev(1'b1, 8);
    edge_sel_i = 2'b00;
    ev(1'b0, 4);

    // Test 4: disarm aborts a long pulse; arm+disarm together stays IDLE.
    ex(0, 0, 1, 0, 0, "t4_arm");
    ex(1, 0, 1, 0, 3, "t4_cnt1");
    ex(2, 0, 1, 0, 8, "t4_cnt2");
    ex(3, 0, 1, 0, 8, "t4_cnt3");
    ex(4, 0, 1, 0, 8, "t4_cnt4");
    ex(5, 1, 0, 1, 8, "t4_fire");
    ex(5, 0, 0, 1, 9, "t4_disarm");
    arm(4'd5, 16'd100, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin ev(1'b1, 4); ev(1'b0, 4); end
    step(3);
    disarm_i = 1'b1; step(1); disarm_i = 1'b0;
    step(3);
    arm_i = 1'b1; disarm_i = 1'b1; step(1); arm_i = 1'b0; disarm_i = 1'b0;
    step(4);

    // Test 5: threshold 0 fires on the first edge; threshold 15 saturates cleanly.
    ex(0, 0, 1, 0, 0, "t5_arm_thr0");
    ex(1, 1, 0, 1, 3, "t5_thr0_fire");
    ex(1, 0, 0, 1, 2, "t5_thr0_done");
    arm(4'd0, 16'd2, 2'b00, 1'b0);
    ev(1'b1, 4); ev(1'b0, 4);
    ex(0, 0, 1, 0, 0, "t5_arm_thr15");
    for (int k = 1; k <= 14; k++) ex(4'(k), 0, 1, 0, (k == 1) ? 3 : 4, "t5_cnt");
    ex(15, 1, 0, 1, 4, "t5_fire15");
    ex(15, 0, 0, 1, 1, "t5_done15");
    arm(4'd15, 16'd1, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) begin ev(1'b1, 2); ev(1'b0, 2); end
    ex(0, 0, 1, 0, 0, "t5_rearm1");
    for (int k = 1; k <= 8; k++) ex(4'(k), 0, 1, 0, (k == 1) ? 3 : 4, "t5_cnt_b");
    arm(4'd15, 16'd1, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) begin ev(1'b1, 2); ev(1'b0, 2); end
    ex(0, 0, 1, 0, 0, "t5_rearm2");
    arm(4'd15, 16'd1, 2'b00, 1'b0);

    // Test 6: edge coincident with arm is dropped; async reset mid-FIRE.
    ex(0, 0, 0, 0, 0, "t6_disarm");
    disarm_i = 1'b1; step(1); disarm_i = 1'b0;
    ex(0, 0, 1, 0, 0, "t6_arm_with_edge");
    ex(1, 0, 1, 0, 7, "t6_cnt1");
    ex(2, 1, 0, 1, 8, "t6_fire");
    ex(0, 0, 0, 0, 0, "t6_reset");
    event_i = 1'b1;
    step(2);
    arm(4'd2, 16'd50, 2'b00, 1'b0);
    ev(1'b0, 4);
    for (int i = 0; i < 2; i++) begin ev(1'b1, 4); ev(1'b0, 4); end
    step(3);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({count_o, trigger_o, armed_o, fired_o} !== 7'b0) begin
      errors++;
      $display("FAIL t6_async_reset: got cnt=%0d trig=%0b armed=%0b fired=%0b, want all 0",
               count_o, trigger_o, armed_o, fired_o);
    end
    step(2);
    rst_i = 1'b0;
    step(3);

    checks++;
    if (exp_val_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expected: got %0d unseen changes (next %s), want 0",
               exp_val_q.size(), exp_tag_q[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_counter_sync.md
Name: event_counter_sync

Overview:
Clocked, parametrised successor to the asynchronous event counter. It synchronises an external event line, detects a selectable edge type and counts qualifying edges while armed. When the count reaches a threshold latched at arm time, it emits a trigger pulse of programmable length. It supports one-shot and auto-rearm modes, so glitch-trigger sequencing can run entirely in the system clock domain.

Parameters:
WIDTH, 32, width of the event counter and threshold
PULSE_WIDTH, 16, width of the trigger pulse length field
SYNC_STAGES, 2, flip-flop stages on event_i (minimum 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
event_i  input  1  raw asynchronous event line
arm_i  input  1  single-cycle pulse: latch config, clear count, enter ARMED
disarm_i  input  1  single-cycle pulse: return to IDLE
edge_sel_i  input  2  00 rising, 01 falling, 10 both, 11 rising
rearm_i  input  1  1 = auto-rearm after pulse; 0 = one-shot
threshold_i  input  WIDTH  edge count that fires the trigger
pulse_len_i  input  PULSE_WIDTH  trigger high time in clk_i cycles
count_o  output  WIDTH  qualifying edges counted since last arm/rearm
trigger_o  output  1  trigger pulse, registered
armed_o  output  1  high in ARMED
fired_o  output  1  sticky; set on first trigger; cleared by arm_i or reset

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is asynchronous and active-high. All flops, including the synchroniser, reset to 0.
- Reset values: count_o=0, trigger_o=0, armed_o=0, fired_o=0, state=IDLE.
- Edge detection:
  - event_i passes through SYNC_STAGES flops, then one history flop.
  - A qualifying edge is detected by comparing the synchroniser output with the history flop, according to edge_sel_i, which is sampled live.
  - Latency from an event_i transition to the count_o update is SYNC_STAGES+1 cycles.
- Configuration latch: arm_i latches threshold_i and pulse_len_i into internal registers. Threshold 0 is treated as 1. pulse_len 0 is treated as 1.
- States:
  - IDLE: no counting; trigger_o=0.
    - arm_i -> ARMED.
  - ARMED: each qualifying edge increments count_o. count_o saturates at all-ones and never wraps.
    - When an edge makes count == latched threshold -> FIRE. trigger_o rises on that same clock edge, registered with the count update.
  - FIRE: trigger_o=1 for exactly the latched pulse_len cycles. fired_o is set. Edges are not counted.
    - On expiry with rearm_i=1: count_o cleared -> ARMED, trigger_o=0.
    - On expiry with rearm_i=0: -> DONE, trigger_o=0.
  - DONE: count_o holds its final value. Edges are ignored.
    - arm_i -> ARMED.
- Priority, highest first: rst_i, disarm_i, arm_i, edge.
  - disarm_i in any state: -> IDLE next cycle, trigger_o=0 next cycle (aborts a pulse), count_o held, fired_o held.
  - arm_i in any state (including FIRE, which aborts the pulse): count_o=0, fired_o=0, config re-latched, -> ARMED. An edge detected on the same cycle as arm_i is dropped.
  - arm_i and disarm_i in the same cycle: disarm wins.
- Auto-rearm: the latched threshold and pulse_len are reused; threshold_i and pulse_len_i are not re-sampled.
- Mid-operation reset: rst_i asserted during FIRE drops trigger_o asynchronously.
- Outputs: armed_o and trigger_o are registered state decodes, with no combinational path from inputs.

Test Plan:
1. Reset, then arm with threshold=3, pulse_len=4, rising edge mode, one-shot. Apply 3 rising edges.
   -> count_o goes 1,2,3. trigger_o high exactly 4 cycles, starting on the cycle count_o=3. State ends in DONE, fired_o=1, armed_o=0. A 4th edge leaves count_o at 3.
2. Edge mode "both", threshold=4. Apply 2 full pulses on event_i.
   -> trigger after the 4th transition. Verify the SYNC_STAGES+1 latency from event_i to count_o.
3. rearm_i=1, threshold=2, pulse_len=1. Apply 6 edges, spaced wider than the pulse.
   -> 3 single-cycle triggers. count_o returns to 0 after each. Edges arriving during FIRE are not counted.
4. Arm with threshold=5, pulse_len=100. During FIRE assert disarm_i, then later arm_i and disarm_i together.
   -> trigger_o low the next cycle. State is IDLE. count_o holds 5. The simultaneous pulse keeps the state in IDLE.
5. WIDTH=4, threshold=0, then threshold=15 with >20 edges while repeatedly re-arming.
   -> threshold 0 fires on the 1st edge. count_o never exceeds 15 and never wraps.
6. Assert rst_i asynchronously mid-FIRE, and arm on the same cycle as an edge.
   -> Under reset, all outputs go to 0 immediately. The edge coincident with arm is not counted (count_o=0).
